// File: rtl/png_stored_encoder_if.sv
// Pixel-in / PNG-byte-out bundle for png_stored_encoder.
// Latency: not applicable (wires only).
// Backpressure: ivalid/iready on pixels, ovalid/oready on bytes.
interface png_stored_encoder_if;
    logic        istart;
    logic [13:0] iwidth;
    logic [15:0] iheight;
    logic        busy;
    logic        ivalid;
    logic        iready;
    logic [7:0]  ipixelr;
    logic [7:0]  ipixelg;
    logic [7:0]  ipixelb;
    logic [7:0]  ipixela;
    logic        ovalid;
    logic        oready;
    logic [7:0]  obyte;
    logic        olast;

    // Pixel/control source side
    modport master (
        output istart, iwidth, iheight, ivalid, ipixelr, ipixelg, ipixelb, ipixela, oready,
        input  busy, iready, ovalid, obyte, olast
    );

    // Encoder side
    modport slave (
        input  istart, iwidth, iheight, ivalid, ipixelr, ipixelg, ipixelb, ipixela, oready,
        output busy, iready, ovalid, obyte, olast
    );
endinterface

// File: rtl/png_stored_encoder.sv
// RGBA8888 pixel stream in, complete PNG (stored-deflate IDAT) byte stream out.
// Latency: first byte valid one cycle after istart is accepted; 1 byte/cycle sustained.
// Backpressure: output register advances only on ~ovalid|oready; missing pixels drop ovalid.
module png_stored_encoder (
    input  logic                 clk,
    input  logic                 rst,
    png_stored_encoder_if.slave  bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SIG      = 4'd1;
    localparam logic [3:0] S_IHDR     = 4'd2;
    localparam logic [3:0] S_IDAT_HDR = 4'd3;
    localparam logic [3:0] S_BLK_HDR  = 4'd4;
    localparam logic [3:0] S_FILT     = 4'd5;
    localparam logic [3:0] S_PIX      = 4'd6;
    localparam logic [3:0] S_ADLER    = 4'd7;
    localparam logic [3:0] S_IDAT_CRC = 4'd8;
    localparam logic [3:0] S_IEND     = 4'd9;
    localparam logic [3:0] S_DONE     = 4'd10;

    localparam logic [16:0] ADLER_MOD = 17'd65521;

    logic [3:0]  state;
    logic [4:0]  idx;          // byte index inside the current header-like state
    logic [13:0] width;
    logic [15:0] height;
    logic [31:0] idat_len;
    logic [15:0] row_cnt;      // current row, 0..height-1, never incremented past the last row
    logic [15:0] row_bytes;    // pixel bytes emitted so far in the current row
    logic        pix_full;     // G/B/A of the current pixel still waiting to go out
    logic [7:0]  hold_g;
    logic [7:0]  hold_b;
    logic [7:0]  hold_a;
    logic [31:0] crc;
    logic [15:0] s1;
    logic [15:0] s2;
    logic        ovalid_q;
    logic        olast_q;
    logic        busy_q;
    logic [7:0]  obyte_q;

    logic [15:0] row_len;
    logic [15:0] blk_len;
    logic [15:0] blk_nlen;
    logic        last_row;
    logic        last_pix_byte;
    logic [31:0] crc_out;
    logic        ld;
    logic        start_ok;
    logic [31:0] start_len;

    logic [7:0]  nb;
    logic        avail;
    logic        last_b;
    logic        crc_en;
    logic        crc_init;
    logic        adl_en;
    logic        take_pix;

    logic [16:0] a1_sum;
    logic [16:0] a2_sum;
    logic [15:0] s1_nxt;
    logic [15:0] s2_nxt;

    assign row_len       = {width, 2'b00};
    assign blk_len       = row_len + 16'd1;
    assign blk_nlen      = ~blk_len;
    assign last_row      = (row_cnt == height - 16'd1);
    assign last_pix_byte = (row_bytes == row_len - 16'd1);
    assign crc_out       = ~crc;
    assign ld            = ~ovalid_q | bus.oready;
    assign start_ok      = bus.istart && (bus.iwidth != 14'd0) && (bus.iheight != 16'd0);
    // zlib header (2) + Adler (4) + per row: block header (5) + filter (1) + pixels
    assign start_len     = 32'd6 + 32'(bus.iheight) * (32'd6 + {16'd0, bus.iwidth, 2'b00});

    assign bus.busy   = busy_q;
    assign bus.ovalid = ovalid_q;
    assign bus.olast  = olast_q;
    assign bus.obyte  = obyte_q;
    // A new pixel is taken only when its R byte can go straight into the output register
    assign bus.iready = (state == S_PIX) && !pix_full && ld;

    // One reflected CRC-32 byte step, eight bit iterations unrolled
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Adler-32 running sums for the candidate byte; each mod is a single subtract
    always_comb begin
        a1_sum = {1'b0, s1} + {9'd0, nb};
        s1_nxt = (a1_sum >= ADLER_MOD) ? 16'(a1_sum - ADLER_MOD) : a1_sum[15:0];
        a2_sum = {1'b0, s2} + {1'b0, s1_nxt};
        s2_nxt = (a2_sum >= ADLER_MOD) ? 16'(a2_sum - ADLER_MOD) : a2_sum[15:0];
    end

    // Select the next byte of the stream and which checksums it feeds
    always_comb begin
        nb       = 8'h00;
        avail    = 1'b0;
        last_b   = 1'b0;
        crc_en   = 1'b0;
        crc_init = 1'b0;
        adl_en   = 1'b0;
        take_pix = 1'b0;
        case (state)
            S_SIG: begin
                avail = 1'b1;
                case (idx)
                    5'd0:    nb = 8'h89;
                    5'd1:    nb = 8'h50;
                    5'd2:    nb = 8'h4E;
                    5'd3:    nb = 8'h47;
                    5'd4:    nb = 8'h0D;
                    5'd5:    nb = 8'h0A;
                    5'd6:    nb = 8'h1A;
                    default: nb = 8'h0A;
                endcase
            end
            S_IHDR: begin
                avail    = 1'b1;
                crc_en   = (idx >= 5'd4) && (idx <= 5'd20);
                crc_init = (idx == 5'd4);
                case (idx)
                    5'd3:    nb = 8'h0D;
                    5'd4:    nb = 8'h49;
                    5'd5:    nb = 8'h48;
                    5'd6:    nb = 8'h44;
                    5'd7:    nb = 8'h52;
                    5'd10:   nb = {2'b00, width[13:8]};
                    5'd11:   nb = width[7:0];
                    5'd14:   nb = height[15:8];
                    5'd15:   nb = height[7:0];
                    5'd16:   nb = 8'h08;
                    5'd17:   nb = 8'h06;
                    5'd21:   nb = crc_out[31:24];
                    5'd22:   nb = crc_out[23:16];
                    5'd23:   nb = crc_out[15:8];
                    5'd24:   nb = crc_out[7:0];
                    default: nb = 8'h00;
                endcase
            end
            S_IDAT_HDR: begin
                avail    = 1'b1;
                crc_en   = (idx >= 5'd4);
                crc_init = (idx == 5'd4);
                case (idx)
                    5'd0:    nb = idat_len[31:24];
                    5'd1:    nb = idat_len[23:16];
                    5'd2:    nb = idat_len[15:8];
                    5'd3:    nb = idat_len[7:0];
                    5'd4:    nb = 8'h49;
                    5'd5:    nb = 8'h44;
                    5'd6:    nb = 8'h41;
                    5'd7:    nb = 8'h54;
                    5'd8:    nb = 8'h78;
                    default: nb = 8'h01;
                endcase
            end
            S_BLK_HDR: begin
                avail  = 1'b1;
                crc_en = 1'b1;
                case (idx)
                    5'd0:    nb = {7'd0, last_row};
                    5'd1:    nb = blk_len[7:0];
                    5'd2:    nb = blk_len[15:8];
                    5'd3:    nb = blk_nlen[7:0];
                    default: nb = blk_nlen[15:8];
                endcase
            end
            S_FILT: begin
                avail  = 1'b1;
                crc_en = 1'b1;
                adl_en = 1'b1;
                nb     = 8'h00;
            end
            S_PIX: begin
                crc_en = 1'b1;
                adl_en = 1'b1;
                if (pix_full) begin
                    avail = 1'b1;
                    case (row_bytes[1:0])
                        2'd1:    nb = hold_g;
                        2'd2:    nb = hold_b;
                        default: nb = hold_a;
                    endcase
                end else begin
                    avail    = bus.ivalid;
                    take_pix = bus.ivalid;
                    nb       = bus.ipixelr;
                end
            end
            S_ADLER: begin
                avail  = 1'b1;
                crc_en = 1'b1;
                case (idx)
                    5'd0:    nb = s2[15:8];
                    5'd1:    nb = s2[7:0];
                    5'd2:    nb = s1[15:8];
                    default: nb = s1[7:0];
                endcase
            end
            S_IDAT_CRC: begin
                avail = 1'b1;
                case (idx)
                    5'd0:    nb = crc_out[31:24];
                    5'd1:    nb = crc_out[23:16];
                    5'd2:    nb = crc_out[15:8];
                    default: nb = crc_out[7:0];
                endcase
            end
            S_IEND: begin
                avail  = 1'b1;
                last_b = (idx == 5'd11);
                case (idx)
                    5'd4:    nb = 8'h49;
                    5'd5:    nb = 8'h45;
                    5'd6:    nb = 8'h4E;
                    5'd7:    nb = 8'h44;
                    5'd8:    nb = 8'hAE;
                    5'd9:    nb = 8'h42;
                    5'd10:   nb = 8'h60;
                    5'd11:   nb = 8'h82;
                    default: nb = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

    // Sequencer: output register, state/index advance, checksum and pixel-hold updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 5'd0;
            width     <= 14'd0;
            height    <= 16'd0;
            idat_len  <= 32'd0;
            row_cnt   <= 16'd0;
            row_bytes <= 16'd0;
            pix_full  <= 1'b0;
            hold_g    <= 8'd0;
            hold_b    <= 8'd0;
            hold_a    <= 8'd0;
            crc       <= 32'd0;
            s1        <= 16'd0;
            s2        <= 16'd0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            busy_q    <= 1'b0;
            obyte_q   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        width     <= bus.iwidth;
                        height    <= bus.iheight;
                        idat_len  <= start_len;
                        row_cnt   <= 16'd0;
                        row_bytes <= 16'd0;
                        pix_full  <= 1'b0;
                        crc       <= 32'hFFFFFFFF;
                        s1        <= 16'd1;
                        s2        <= 16'd0;
                        busy_q    <= 1'b1;
                        // Signature byte 0 goes out immediately
                        obyte_q   <= 8'h89;
                        ovalid_q  <= 1'b1;
                        olast_q   <= 1'b0;
                        idx       <= 5'd1;
                        state     <= S_SIG;
                    end
                end
                S_DONE: begin
                    if (bus.oready) begin
                        ovalid_q <= 1'b0;
                        olast_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    if (ld) begin
                        if (!avail) begin
                            ovalid_q <= 1'b0;
                        end else begin
                            obyte_q  <= nb;
                            ovalid_q <= 1'b1;
                            olast_q  <= last_b;
                            if (crc_en) begin
                                crc <= crc_step(crc_init ? 32'hFFFFFFFF : crc, nb);
                            end
                            if (adl_en) begin
                                s1 <= s1_nxt;
                                s2 <= s2_nxt;
                            end
                            idx <= idx + 5'd1;
                            case (state)
                                S_SIG:      if (idx == 5'd7)  begin idx <= 5'd0; state <= S_IHDR;     end
                                S_IHDR:     if (idx == 5'd24) begin idx <= 5'd0; state <= S_IDAT_HDR; end
                                S_IDAT_HDR: if (idx == 5'd9)  begin idx <= 5'd0; state <= S_BLK_HDR;  end
                                S_BLK_HDR:  if (idx == 5'd4)  begin idx <= 5'd0; state <= S_FILT;     end
                                S_FILT: begin
                                    row_bytes <= 16'd0;
                                    state     <= S_PIX;
                                end
                                S_PIX: begin
                                    if (take_pix) begin
                                        pix_full <= 1'b1;
                                        hold_g   <= bus.ipixelg;
                                        hold_b   <= bus.ipixelb;
                                        hold_a   <= bus.ipixela;
                                    end
                                    if (row_bytes[1:0] == 2'd3) begin
                                        pix_full <= 1'b0;
                                    end
                                    if (last_pix_byte) begin
                                        idx <= 5'd0;
                                        if (last_row) begin
                                            state <= S_ADLER;
                                        end else begin
                                            row_cnt <= row_cnt + 16'd1;
                                            state   <= S_BLK_HDR;
                                        end
                                    end else begin
                                        row_bytes <= row_bytes + 16'd1;
                                    end
                                end
                                S_ADLER:    if (idx == 5'd3)  begin idx <= 5'd0; state <= S_IDAT_CRC; end
                                S_IDAT_CRC: if (idx == 5'd3)  begin idx <= 5'd0; state <= S_IEND;     end
                                S_IEND:     if (idx == 5'd11) begin idx <= 5'd0; state <= S_DONE;     end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_png_stored_encoder.sv
// Randomised scoreboard bench for png_stored_encoder against a byte-level PNG model.
// Latency: checks are per handshaken byte, independent of timing.
// Backpressure: random oready and ivalid bubbles; stalled bytes must hold.
module tb_png_stored_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    png_stored_encoder_if bus();
    png_stored_encoder dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [8:0]  exp_q[$];     // {last, byte}
    logic [7:0]  got_q[$];
    logic [7:0]  mdl[$];
    logic [7:0]  first_got[$];
    logic [7:0]  ref_got[$];
    logic [31:0] pix_q[$];
    int          a1;
    int          a2;
    bit          rnd_rdy = 1'b0;
    bit          rnd_vld = 1'b0;
    bit          busy_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic p8(input logic [7:0] b);
        mdl.push_back(b);
    endtask

    task automatic p32(input logic [31:0] v);
        p8(v[31:24]); p8(v[23:16]); p8(v[15:8]); p8(v[7:0]);
    endtask

    // Byte of zlib payload that Adler-32 covers
    task automatic praw(input logic [7:0] b);
        p8(b);
        a1 = (a1 + int'(b)) % 65521;
        a2 = (a2 + a1) % 65521;
    endtask

    function automatic logic [31:0] crc_rng(input int s, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = s; i < s + n; i++) begin
            c = c ^ {24'd0, mdl[i]};
            for (int k = 0; k < 8; k++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'd0);
        end
        return ~c;
    endfunction

    task automatic build_model(input int w, input int h);
        int s, lenpos, dlen;
        logic [15:0] len16;
        logic [31:0] p;
        mdl.delete();
        p8(8'h89); p8(8'h50); p8(8'h4E); p8(8'h47); p8(8'h0D); p8(8'h0A); p8(8'h1A); p8(8'h0A);
        p32(32'd13);
        s = mdl.size();
        p8(8'h49); p8(8'h48); p8(8'h44); p8(8'h52);
        p32(32'(w)); p32(32'(h));
        p8(8'h08); p8(8'h06); p8(8'h00); p8(8'h00); p8(8'h00);
        p32(crc_rng(s, mdl.size() - s));
        lenpos = mdl.size();
        p32(32'd0);
        s = mdl.size();
        p8(8'h49); p8(8'h44); p8(8'h41); p8(8'h54);
        p8(8'h78); p8(8'h01);
        a1 = 1; a2 = 0;
        len16 = 16'(4 * w + 1);
        for (int y = 0; y < h; y++) begin
            p8((y == h - 1) ? 8'h01 : 8'h00);
            p8(len16[7:0]); p8(len16[15:8]);
            p8(~len16[7:0]); p8(~len16[15:8]);
            praw(8'h00);
            for (int x = 0; x < w; x++) begin
                p = pix_q[y * w + x];
                praw(p[31:24]); praw(p[23:16]); praw(p[15:8]); praw(p[7:0]);
            end
        end
        p32({a2[15:0], a1[15:0]});
        dlen = mdl.size() - s - 4;
        mdl[lenpos]     = dlen[31:24];
        mdl[lenpos + 1] = dlen[23:16];
        mdl[lenpos + 2] = dlen[15:8];
        mdl[lenpos + 3] = dlen[7:0];
        p32(crc_rng(s, mdl.size() - s));
        p32(32'd0);
        s = mdl.size();
        p8(8'h49); p8(8'h45); p8(8'h4E); p8(8'h44);
        p32(crc_rng(s, 4));
    endtask

    function automatic logic [31:0] got32(input int i);
        return {got_q[i], got_q[i + 1], got_q[i + 2], got_q[i + 3]};
    endfunction

    // ---------------- oready driver ----------------
    initial begin
        bus.oready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.oready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : mon
        logic       ps;
        logic [7:0] pb;
        logic       pl;
        logic [8:0] e;
        ps = 1'b0; pb = 8'd0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ps = 1'b0;
                busy_chk = 1'b0;
            end else begin
                if (busy_chk) begin
                    chk("busy_after_last", 32'(bus.busy), 32'd0);
                    busy_chk = 1'b0;
                end
                if (ps) begin
                    chk("hold_valid", 32'(bus.ovalid), 32'd1);
                    chk("hold_byte", 32'(bus.obyte), 32'(pb));
                    chk("hold_last", 32'(bus.olast), 32'(pl));
                end
                if (bus.ovalid && bus.oready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %h expected none", bus.obyte);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", 32'(bus.obyte), 32'(e[7:0]));
                        chk("last", 32'(bus.olast), 32'(e[8]));
                        if (e[8]) busy_chk = 1'b1;
                    end
                    got_q.push_back(bus.obyte);
                end
                ps = bus.ovalid & ~bus.oready;
                pb = bus.obyte;
                pl = bus.olast;
            end
        end
    end

    // gen: 0 random, 1 gradient, 2 fixed FF000080, 3 reuse current pixels
    task automatic run_frame(input int w, input int h, input int gen, input bit poke, input int abort_at);
        int pi, cyc, budget;
        logic xfer;
        logic [31:0] p;
        if (gen != 3) begin
            pix_q.delete();
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    if (gen == 0)      p = $urandom;
                    else if (gen == 1) p = {8'(x * 80), 8'(y * 120), 8'((x + y) * 40), 8'hFF};
                    else               p = 32'hFF000080;
                    pix_q.push_back(p);
                end
        end
        build_model(w, h);
        foreach (mdl[i]) exp_q.push_back({(i == mdl.size() - 1), mdl[i]});
        got_q.delete();
        budget = 8 * mdl.size() + 200;
        @(posedge clk);
        #1 bus.istart = 1'b1; bus.iwidth = 14'(w); bus.iheight = 16'(h);
        @(posedge clk);
        #1 bus.istart = 1'b0;
        pi = 0; cyc = 0;
        while (pi < w * h) begin
            p = pix_q[pi];
            bus.ivalid  = rnd_vld ? ($urandom_range(0, 3) != 0) : 1'b1;
            {bus.ipixelr, bus.ipixelg, bus.ipixelb, bus.ipixela} = p;
            bus.istart  = poke && (pi == 1);
            bus.iwidth  = (poke && pi == 1) ? 14'd3 : 14'(w);
            if (abort_at >= 0 && pi == abort_at) begin
                #3 rst = 1'b1;
                #1;
                chk("abort_ovalid", 32'(bus.ovalid), 32'd0);
                chk("abort_iready", 32'(bus.iready), 32'd0);
                chk("abort_busy", 32'(bus.busy), 32'd0);
                chk("abort_olast", 32'(bus.olast), 32'd0);
                exp_q.delete();
                got_q.delete();
                bus.ivalid = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            @(negedge clk);
            xfer = bus.ivalid & bus.iready;
            @(posedge clk);
            #1;
            if (xfer) pi++;
            cyc++;
            if (cyc > budget) begin
                chk("timeout_pixels", 32'(pi), 32'(w * h));
                break;
            end
        end
        bus.ivalid = 1'b0;
        bus.istart = 1'b0;
        bus.iwidth = 14'(w);
        cyc = 0;
        while (bus.busy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame_done_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("frame_exp_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_len", 32'(got_q.size()), 32'(mdl.size()));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        bus.istart = 1'b0; bus.iwidth = 14'd1; bus.iheight = 16'd1;
        bus.ivalid = 1'b0;
        bus.ipixelr = 8'd0; bus.ipixelg = 8'd0; bus.ipixelb = 8'd0; bus.ipixela = 8'd0;
        #12;
        chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("rst_iready", 32'(bus.iready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_olast", 32'(bus.olast), 32'd0);
        chk("rst_obyte", 32'(bus.obyte), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1x1 single pixel
        run_frame(1, 1, 2, 1'b0, -1);
        chk("1x1_len", 32'(got_q.size()), 32'd73);
        chk("1x1_ihdr_crc", got32(29), 32'h1F15C489);
        chk("1x1_idat_len", got32(33), 32'h00000010);
        chk("1x1_bfinal", 32'(got_q[43]), 32'h01);
        chk("1x1_len_nlen", got32(44), 32'h0500FAFF);
        chk("1x1_adler", got32(53), 32'h04810180);
        chk("1x1_iend_crc", got32(69), 32'hAE426082);
        first_got = got_q;

        // 3x2 gradient
        run_frame(3, 2, 1, 1'b0, -1);
        chk("3x2_idat_len", got32(33), 32'h0000002A);
        chk("3x2_bfinal0", 32'(got_q[43]), 32'h00);
        chk("3x2_bfinal1", 32'(got_q[61]), 32'h01);

        // 17x5 random pixels, clean then with backpressure and bubbles
        run_frame(17, 5, 0, 1'b0, -1);
        ref_got = got_q;
        rnd_rdy = 1'b1; rnd_vld = 1'b1;
        run_frame(17, 5, 3, 1'b0, -1);
        rnd_rdy = 1'b0; rnd_vld = 1'b0;
        mism = 0;
        foreach (ref_got[i]) if (i >= got_q.size() || got_q[i] !== ref_got[i]) mism++;
        chk("bp_stream_identical", 32'(mism), 32'd0);

        // Zero dimensions are ignored
        @(posedge clk);
        #1 bus.istart = 1'b1; bus.iwidth = 14'd0; bus.iheight = 16'd3;
        @(posedge clk);
        #1 bus.iwidth = 14'd4; bus.iheight = 16'd0;
        @(posedge clk);
        #1 bus.istart = 1'b0; bus.iwidth = 14'd1; bus.iheight = 16'd1;
        repeat (4) @(negedge clk);
        chk("zero_dim_busy", 32'(bus.busy), 32'd0);
        chk("zero_dim_ovalid", 32'(bus.ovalid), 32'd0);

        // istart while busy has no effect
        run_frame(2, 2, 0, 1'b1, -1);

        // Reset mid-PIX, then the 1x1 frame must reproduce exactly
        run_frame(4, 3, 0, 1'b0, 2);
        repeat (2) @(negedge clk);
        run_frame(1, 1, 2, 1'b0, -1);
        mism = 0;
        foreach (first_got[i]) if (i >= got_q.size() || got_q[i] !== first_got[i]) mism++;
        chk("after_abort_identical", 32'(mism), 32'd0);

        // Widest row
        run_frame(16383, 1, 0, 1'b0, -1);
        chk("wide_len_nlen", got32(44), 32'hFDFF0200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
